// File: rtl/calc_drv_pkg.sv
// Shared types and constants for the calculator port driver.
// Channel/sequencer state encodings and counter sizing helper.
package calc_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    WAIT,
    DONE
  } chan_state_e;

  typedef enum logic {
    RUN,
    HOLD
  } rst_state_e;

  localparam int CMD_NOP   = 0;
  localparam int RESP_NONE = 0;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calc_port_fsm.sv
// One calculator request channel: cmd+opA, nop+opB, wait for response.
// Result is held until consumed; a silent DUT yields a timeout result.
module calc_port_fsm
  import calc_drv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int RESP_W  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              SysClk,
  input  logic              Rst,
  input  logic              flush,
  input  logic              txn_valid,
  output logic              txn_ready,
  input  logic [CMD_W-1:0]  txn_cmd,
  input  logic [DATA_W-1:0] txn_opa,
  input  logic [DATA_W-1:0] txn_opb,
  output logic [CMD_W-1:0]  req_cmd_in,
  output logic [DATA_W-1:0] req_data_in,
  input  logic [RESP_W-1:0] out_resp,
  input  logic [DATA_W-1:0] out_data,
  output logic              rslt_valid,
  input  logic              rslt_ready,
  output logic [DATA_W-1:0] rslt_data,
  output logic [RESP_W-1:0] rslt_resp,
  output logic              rslt_tmo,
  output logic              spur_resp
);

  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  chan_state_e       st;
  logic [DATA_W-1:0] opb_q;
  logic [TW-1:0]     cnt;
  logic              resp_hit;

  assign resp_hit = (out_resp != RESP_W'(RESP_NONE));

  // Channel FSM; all outputs registered alongside the state.
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      st          <= IDLE;
      opb_q       <= '0;
      cnt         <= '0;
      txn_ready   <= 1'b0;
      req_cmd_in  <= '0;
      req_data_in <= '0;
      rslt_valid  <= 1'b0;
      rslt_data   <= '0;
      rslt_resp   <= '0;
      rslt_tmo    <= 1'b0;
      spur_resp   <= 1'b0;
    end else if (flush) begin
      st          <= IDLE;
      cnt         <= '0;
      txn_ready   <= 1'b0;
      req_cmd_in  <= '0;
      req_data_in <= '0;
      rslt_valid  <= 1'b0;
      rslt_data   <= '0;
      rslt_resp   <= '0;
      rslt_tmo    <= 1'b0;
      spur_resp   <= 1'b0;
    end else begin
      if (resp_hit && st != WAIT)
        spur_resp <= 1'b1;
      unique case (st)
        IDLE: begin
          if (txn_valid && txn_ready) begin
            req_cmd_in  <= txn_cmd;
            req_data_in <= txn_opa;
            opb_q       <= txn_opb;
            txn_ready   <= 1'b0;
            st          <= CMD;
          end else begin
            txn_ready <= 1'b1;
          end
        end
        CMD: begin
          req_cmd_in  <= CMD_W'(CMD_NOP);
          req_data_in <= opb_q;
          st          <= DATA;
        end
        DATA: begin
          cnt <= '0;
          st  <= WAIT;
        end
        WAIT: begin
          if (resp_hit) begin
            rslt_data  <= out_data;
            rslt_resp  <= out_resp;
            rslt_tmo   <= 1'b0;
            rslt_valid <= 1'b1;
            st         <= DONE;
          end else if (cnt == TLAST) begin
            rslt_data  <= '0;
            rslt_resp  <= '0;
            rslt_tmo   <= 1'b1;
            rslt_valid <= 1'b1;
            st         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (rslt_ready) begin
            rslt_valid <= 1'b0;
            txn_ready  <= 1'b1;
            st         <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/calc_port_driver.sv
// Multi-port calculator request driver with DUT reset sequencer.
// Each port runs an independent calc_port_fsm; HOLD flushes them all.
module calc_port_driver
  import calc_drv_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int CMD_W      = 4,
  parameter int RESP_W     = 2,
  parameter int TIMEOUT    = 64,
  parameter int RST_CYCLES = 7
) (
  input  logic                             SysClk,
  input  logic                             Rst,
  input  logic                             rst_req,
  output logic                             dut_rst,
  input  logic [NUM_PORTS-1:0]             txn_valid,
  output logic [NUM_PORTS-1:0]             txn_ready,
  input  logic [NUM_PORTS-1:0][CMD_W-1:0]  txn_cmd,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] txn_opa,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] txn_opb,
  output logic [NUM_PORTS-1:0][CMD_W-1:0]  req_cmd_in,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] req_data_in,
  input  logic [NUM_PORTS-1:0][RESP_W-1:0] out_resp,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0]             rslt_valid,
  input  logic [NUM_PORTS-1:0]             rslt_ready,
  output logic [NUM_PORTS-1:0][DATA_W-1:0] rslt_data,
  output logic [NUM_PORTS-1:0][RESP_W-1:0] rslt_resp,
  output logic [NUM_PORTS-1:0]             rslt_tmo,
  output logic [NUM_PORTS-1:0]             spur_resp
);

  localparam int RW = cnt_w(RST_CYCLES);
  localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);

  rst_state_e    rst_st;
  logic [RW-1:0] rst_cnt;
  logic          hold_nxt;

  // Channels see the sequencer's next state so their registered
  // outputs change on the same edge as dut_rst.
  assign hold_nxt = rst_req || (rst_st == HOLD && rst_cnt != RLAST);

  // Reset sequencer: hold dut_rst for RST_CYCLES, restart on new request.
  always_ff @(posedge SysClk or posedge Rst) begin
    if (Rst) begin
      rst_st  <= HOLD;
      rst_cnt <= '0;
      dut_rst <= 1'b1;
    end else if (rst_req) begin
      rst_st  <= HOLD;
      rst_cnt <= '0;
      dut_rst <= 1'b1;
    end else if (rst_st == HOLD) begin
      if (rst_cnt == RLAST) begin
        rst_st  <= RUN;
        dut_rst <= 1'b0;
      end else begin
        rst_cnt <= rst_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    calc_port_fsm #(
      .DATA_W (DATA_W),
      .CMD_W  (CMD_W),
      .RESP_W (RESP_W),
      .TIMEOUT(TIMEOUT)
    ) u_fsm (
      .SysClk     (SysClk),
      .Rst        (Rst),
      .flush      (hold_nxt),
      .txn_valid  (txn_valid[i]),
      .txn_ready  (txn_ready[i]),
      .txn_cmd    (txn_cmd[i]),
      .txn_opa    (txn_opa[i]),
      .txn_opb    (txn_opb[i]),
      .req_cmd_in (req_cmd_in[i]),
      .req_data_in(req_data_in[i]),
      .out_resp   (out_resp[i]),
      .out_data   (out_data[i]),
      .rslt_valid (rslt_valid[i]),
      .rslt_ready (rslt_ready[i]),
      .rslt_data  (rslt_data[i]),
      .rslt_resp  (rslt_resp[i]),
      .rslt_tmo   (rslt_tmo[i]),
      .spur_resp  (spur_resp[i])
    );
  end

endmodule

// File: tb/tb_calc_port_driver.sv
// Self-checking bench for calc_port_driver.
// Vector table, concurrent/reset/spurious sequences, random vs model.
module tb_calc_port_driver;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int RW = 2;
  localparam int T  = 64;
  localparam int RC = 7;

  logic SysClk = 1'b0;
  logic Rst;
  logic rst_req;
  logic dut_rst;
  logic [NP-1:0]         txn_valid, txn_ready;
  logic [NP-1:0]         rslt_valid, rslt_ready;
  logic [NP-1:0]         rslt_tmo, spur_resp;
  logic [NP-1:0][CW-1:0] txn_cmd, req_cmd_in;
  logic [NP-1:0][DW-1:0] txn_opa, txn_opb;
  logic [NP-1:0][DW-1:0] req_data_in, out_data, rslt_data;
  logic [NP-1:0][RW-1:0] out_resp, rslt_resp;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int            p;
    logic [CW-1:0] cmd;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    int            dly;
    logic [DW-1:0] rd;
    logic [RW-1:0] rr;
    logic [DW-1:0] ed;
    logic [RW-1:0] er;
    logic          et;
    int            el;
  } vec_t;

  vec_t tbl[6];

  always #5 SysClk = ~SysClk;

  calc_port_driver #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .CMD_W     (CW),
    .RESP_W    (RW),
    .TIMEOUT   (T),
    .RST_CYCLES(RC)
  ) dut (
    .SysClk     (SysClk),
    .Rst        (Rst),
    .rst_req    (rst_req),
    .dut_rst    (dut_rst),
    .txn_valid  (txn_valid),
    .txn_ready  (txn_ready),
    .txn_cmd    (txn_cmd),
    .txn_opa    (txn_opa),
    .txn_opb    (txn_opb),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .rslt_valid (rslt_valid),
    .rslt_ready (rslt_ready),
    .rslt_data  (rslt_data),
    .rslt_resp  (rslt_resp),
    .rslt_tmo   (rslt_tmo),
    .spur_resp  (spur_resp)
  );

  task automatic chk(input string nm, input int p,
                     input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL p%0d %s: got %0h expected %0h", p, nm, a, e);
    end
  endtask

  // Reference: a non-zero response inside the TIMEOUT-cycle window wins,
  // otherwise the channel reports a zeroed timeout after TIMEOUT cycles.
  function automatic void model(input int dly, input logic [DW-1:0] rd,
                                input logic [RW-1:0] rr,
                                output logic [DW-1:0] ed,
                                output logic [RW-1:0] er,
                                output logic et, output int el);
    if (rr != 0 && dly < T) begin
      ed = rd; er = rr; et = 1'b0; el = dly + 1;
    end else begin
      ed = '0; er = '0; et = 1'b1; el = T;
    end
  endfunction

  task automatic run_txn(input int p, input logic [CW-1:0] cmd,
                         input logic [DW-1:0] opa, input logic [DW-1:0] opb,
                         input int dly, input logic [DW-1:0] rd,
                         input logic [RW-1:0] rr, input logic [DW-1:0] ed,
                         input logic [RW-1:0] er, input logic et,
                         input int el, input int hold);
    int w = 0;
    int lat = 0;
    while (!txn_ready[p] && w < 200) begin
      @(negedge SysClk);
      w++;
    end
    chk("ready before offer", p, txn_ready[p], 1);
    txn_valid[p] = 1'b1;
    txn_cmd[p]   = cmd;
    txn_opa[p]   = opa;
    txn_opb[p]   = opb;
    @(negedge SysClk);
    txn_valid[p] = 1'b0;
    chk("cmd phase cmd", p, req_cmd_in[p], cmd);
    chk("cmd phase data", p, req_data_in[p], opa);
    chk("ready after accept", p, txn_ready[p], 0);
    @(negedge SysClk);
    chk("data phase cmd", p, req_cmd_in[p], 0);
    chk("data phase data", p, req_data_in[p], opb);
    @(negedge SysClk);
    for (int k = 0; k < T + 4; k++) begin
      if (k == dly) begin
        out_resp[p] = rr;
        out_data[p] = rd;
      end
      @(negedge SysClk);
      out_resp[p] = '0;
      out_data[p] = '0;
      if (rslt_valid[p]) begin
        lat = k + 1;
        break;
      end
    end
    chk("wait latency", p, lat, el);
    chk("rslt_data", p, rslt_data[p], ed);
    chk("rslt_resp", p, rslt_resp[p], er);
    chk("rslt_tmo", p, rslt_tmo[p], et);
    repeat (hold) @(negedge SysClk);
    chk("valid held", p, rslt_valid[p], 1);
    chk("data held", p, rslt_data[p], ed);
    rslt_ready[p] = 1'b1;
    @(negedge SysClk);
    rslt_ready[p] = 1'b0;
    chk("valid cleared", p, rslt_valid[p], 0);
    chk("ready again", p, txn_ready[p], 1);
    chk("no spur", p, spur_resp[p], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int bad;
    int p;
    int dly;
    int hold;
    logic [CW-1:0] cmd;
    logic [DW-1:0] opa, opb, rd, ed;
    logic [RW-1:0] rr, er;
    logic          et;
    int            el;

    tbl[0] = '{0, 4'd1, 32'd5, 32'd7, 2, 32'd12, 2'd1,
               32'd12, 2'd1, 1'b0, 3};
    tbl[1] = '{2, 4'd3, 32'h11, 32'h22, 99, 32'h55, 2'd1,
               32'd0, 2'd0, 1'b1, 64};
    tbl[2] = '{2, 4'd4, 32'h33, 32'h44, 63, 32'hABCD, 2'd3,
               32'hABCD, 2'd3, 1'b0, 64};
    tbl[3] = '{1, 4'd0, 32'h1, 32'h2, 99, 32'h9, 2'd1,
               32'd0, 2'd0, 1'b1, 64};
    tbl[4] = '{3, 4'd15, 32'hFFFFFFFF, 32'h0, 0, 32'hFFFFFFFF, 2'd2,
               32'hFFFFFFFF, 2'd2, 1'b0, 1};
    tbl[5] = '{0, 4'd9, 32'h77, 32'h88, 64, 32'h5, 2'd1,
               32'd0, 2'd0, 1'b1, 64};

    Rst        = 1'b1;
    rst_req    = 1'b0;
    txn_valid  = '0;
    txn_cmd    = '0;
    txn_opa    = '0;
    txn_opb    = '0;
    out_resp   = '0;
    out_data   = '0;
    rslt_ready = '0;
    repeat (3) @(negedge SysClk);
    chk("reset dut_rst", 0, dut_rst, 1);
    chk("reset txn_ready", 0, txn_ready, 0);
    chk("reset rslt_valid", 0, rslt_valid, 0);
    Rst = 1'b0;
    h = 0;
    while (dut_rst && h < 50) begin
      @(negedge SysClk);
      h++;
    end
    chk("dut_rst cycles after Rst", 0, h, RC);
    chk("ready after seq", 0, txn_ready, 4'hF);
    chk("rslt_valid idle", 0, rslt_valid, 0);
    chk("spur idle", 0, spur_resp, 0);
    chk("req_cmd idle", 0, req_cmd_in, 0);
    chk("req_data idle", 0, req_data_in, 0);

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].p, tbl[i].cmd, tbl[i].opa, tbl[i].opb,
              tbl[i].dly, tbl[i].rd, tbl[i].rr, tbl[i].ed,
              tbl[i].er, tbl[i].et, tbl[i].el, 2);

    fork
      run_txn(0, 4'd2, 32'h100, 32'h200, 4, 32'hA0, 2'd1,
              32'hA0, 2'd1, 1'b0, 5, 0);
      run_txn(1, 4'd3, 32'h101, 32'h201, 2, 32'hA1, 2'd2,
              32'hA1, 2'd2, 1'b0, 3, 20);
      run_txn(2, 4'd4, 32'h102, 32'h202, 6, 32'hA2, 2'd3,
              32'hA2, 2'd3, 1'b0, 7, 0);
      run_txn(3, 4'd5, 32'h103, 32'h203, 0, 32'hA3, 2'd1,
              32'hA3, 2'd1, 1'b0, 1, 0);
    join

    @(negedge SysClk);
    txn_valid[0] = 1'b1;
    txn_cmd[0]   = 4'd2;
    txn_opa[0]   = 32'h1;
    txn_opb[0]   = 32'h2;
    @(negedge SysClk);
    txn_valid[0] = 1'b0;
    repeat (4) @(negedge SysClk);
    rst_req = 1'b1;
    @(negedge SysClk);
    rst_req = 1'b0;
    h = 0;
    bad = 0;
    while (dut_rst && h < 40) begin
      h++;
      if (txn_ready != 0 || req_cmd_in != 0 || req_data_in != 0 ||
          rslt_valid != 0)
        bad++;
      @(negedge SysClk);
    end
    chk("rst_req hold cycles", 0, h, RC);
    chk("outputs quiet in hold", 0, bad, 0);
    chk("ready after rst_req", 0, txn_ready, 4'hF);
    repeat (3) @(negedge SysClk);
    chk("dropped txn no result", 0, rslt_valid, 0);

    rst_req = 1'b1;
    @(negedge SysClk);
    h = 0;
    for (int i = 1; i < 40 && dut_rst; i++) begin
      h++;
      rst_req = (i == 4);
      @(negedge SysClk);
    end
    rst_req = 1'b0;
    chk("extended hold cycles", 0, h, 11);

    out_resp[3] = 2'd2;
    @(negedge SysClk);
    out_resp[3] = '0;
    chk("spur set", 3, spur_resp, 4'b1000);
    chk("spur no result", 3, rslt_valid[3], 0);
    repeat (3) @(negedge SysClk);
    chk("spur sticky", 3, spur_resp[3], 1);
    rst_req = 1'b1;
    @(negedge SysClk);
    rst_req = 1'b0;
    chk("spur cleared", 3, spur_resp, 0);
    h = 0;
    while (dut_rst && h < 40) begin
      @(negedge SysClk);
      h++;
    end
    chk("hold done after spur", 3, dut_rst, 0);

    for (int i = 0; i < 15; i++) begin
      p    = $urandom_range(0, NP - 1);
      cmd  = CW'($urandom_range(0, 15));
      opa  = $urandom;
      opb  = $urandom;
      dly  = $urandom_range(0, T + 4);
      rd   = $urandom;
      rr   = RW'($urandom_range(0, 3));
      hold = $urandom_range(0, 3);
      model(dly, rd, rr, ed, er, et, el);
      run_txn(p, cmd, opa, opb, dly, rd, rr, ed, er, et, el, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
